// File: rtl/matmul_pkg.sv
// Shared types and default widths for the matrix-multiplier memory subsystem.
package matmul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the shared memory port.
// Handshake: a requester holds req and its fields until it sees a one-cycle ack;
// the arbiter holds mem_req and fields until mem_ack (or the watchdog) completes.
interface mem_port_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       rdata;
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_ack;
  logic [DATA_W-1:0]       mem_rdata;
  logic [IDX_W-1:0]        grant_id;
  logic                    busy;
  logic                    timeout_err;
  logic                    err_clr;

  modport master (
    output req, we, addr, wdata, mem_ack, mem_rdata, err_clr,
    input  ack, rdata, mem_req, mem_we, mem_addr, mem_wdata, grant_id, busy, timeout_err
  );

  modport slave (
    input  req, we, addr, wdata, mem_ack, mem_rdata, err_clr,
    output ack, rdata, mem_req, mem_we, mem_addr, mem_wdata, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit starting at ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N_REQ)) sum = sum - (IDX_W + 1)'(N_REQ);
      cand = sum[IDX_W-1:0];
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among N_REQ requesters, with a
// watchdog that force-completes unanswered transactions and flags a sticky error.
module mem_port_arbiter
  import matmul_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus,
  output arb_state_t          state_dbg
);
  localparam int IDX_W    = $clog2(N_REQ);
  localparam int WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int WD_LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic              in_busy, wd_fire, done;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req   (bus.req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == IDX_W'(i)) begin
        sel_we    = bus.we[i];
        sel_addr  = bus.addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // A real mem_ack in the watchdog's last cycle takes precedence over the timeout.
  always_comb begin
    in_busy = (state_q == BUSY);
    wd_fire = in_busy && !bus.mem_ack && (TIMEOUT != 0) && (wd_cnt_q == WD_W'(WD_LIMIT));
    done    = in_busy && (bus.mem_ack || wd_fire);

    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    wd_cnt_d      = '0;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_idx;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_id_q == IDX_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.err_clr) timeout_err_d = 1'b0;
    if (wd_fire)     timeout_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      bus.ack[i] = done && (grant_id_q == IDX_W'(i));
    end
  end

  assign bus.rdata       = (in_busy && bus.mem_ack) ? bus.mem_rdata : '0;
  assign bus.mem_req     = in_busy;
  assign bus.mem_we      = in_busy ? sel_we : 1'b0;
  assign bus.mem_addr    = in_busy ? sel_addr : '0;
  assign bus.mem_wdata   = in_busy ? sel_wdata : '0;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = in_busy;
  assign bus.timeout_err = timeout_err_q;
  assign state_dbg       = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with N_REQ=3 and an 8-cycle watchdog.
module tb_mem_port_arbiter;
  import matmul_pkg::*;

  localparam int N_REQ = 3;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic       clk;
  logic       reset_n;
  arb_state_t state_dbg;
  int         checks;
  int         errors;
  logic [1:0] exp_q[$];

  mem_port_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.N_REQ(N_REQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL time_limit got running exp finished");
    $fatal(1, "time limit");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i]              = 1'b1;
    bus.we[i]               = w;
    bus.addr[i*AW +: AW]    = a;
    bus.wdata[i*DW +: DW]   = d;
  endtask

  initial begin
    logic [1:0] g;
    checks        = 0;
    errors        = 0;
    reset_n       = 1'b0;
    bus.req       = '0;
    bus.we        = '0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    bus.err_clr   = 1'b0;

    // Reset values
    tick();
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ack", 64'(bus.ack), 64'd0);
    chk("rst_grant", 64'(bus.grant_id), 64'd0);
    chk("rst_terr", 64'(bus.timeout_err), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    reset_n = 1'b1;
    tick();

    // Round-robin: all requesting, memory acks immediately
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, AW'(32'h100 + i * 4), '0);
    bus.mem_ack = 1'b1;
    for (int n = 0; n < 6; n++) exp_q.push_back(2'(n % 3));
    for (int n = 0; n < 6; n++) begin
      tick();
      g = exp_q.pop_front();
      chk("rr_busy", 64'(bus.busy), 64'd1);
      chk("rr_grant", 64'(bus.grant_id), 64'(g));
      chk("rr_ack", 64'(bus.ack), 64'(3'b001 << g));
      chk("rr_addr", 64'(bus.mem_addr), 64'(32'h100 + 32'(g) * 4));
      tick();
      chk("rr_idle_ack", 64'(bus.ack), 64'd0);
      chk("rr_idle_busy", 64'(bus.busy), 64'd0);
      if (n == 5) begin
        bus.req     = '0;
        bus.mem_ack = 1'b0;
      end
    end

    // Single write requester, memory acks 2 cycles after mem_req
    set_req(1, 1'b1, 32'h40, 32'hDEADBEEF);
    settle();
    chk("wr_c0_mem_req", 64'(bus.mem_req), 64'd0);
    chk("wr_c0_addr", 64'(bus.mem_addr), 64'd0);
    tick();
    chk("wr_c1_mem_req", 64'(bus.mem_req), 64'd1);
    chk("wr_c1_addr", 64'(bus.mem_addr), 64'h40);
    chk("wr_c1_we", 64'(bus.mem_we), 64'd1);
    chk("wr_c1_wdata", 64'(bus.mem_wdata), 64'hDEADBEEF);
    chk("wr_c1_grant", 64'(bus.grant_id), 64'd1);
    chk("wr_c1_ack", 64'(bus.ack), 64'd0);
    tick();
    chk("wr_c2_ack", 64'(bus.ack), 64'd0);
    tick();
    bus.mem_ack = 1'b1;
    settle();
    chk("wr_c3_ack", 64'(bus.ack), 64'b010);
    tick();
    bus.req     = '0;
    bus.we      = '0;
    bus.mem_ack = 1'b0;
    settle();
    chk("wr_c4_ack", 64'(bus.ack), 64'd0);
    chk("wr_c4_mem_req", 64'(bus.mem_req), 64'd0);
    chk("wr_c4_grant", 64'(bus.grant_id), 64'd1);

    // Read return on requester 2
    set_req(2, 1'b0, 32'h80, 32'h0);
    tick();
    chk("rd_grant", 64'(bus.grant_id), 64'd2);
    chk("rd_we", 64'(bus.mem_we), 64'd0);
    chk("rd_addr", 64'(bus.mem_addr), 64'h80);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h12345678;
    settle();
    chk("rd_ack", 64'(bus.ack), 64'b100);
    chk("rd_rdata", 64'(bus.rdata), 64'h12345678);
    tick();
    bus.req     = '0;
    bus.mem_ack = 1'b0;
    settle();
    chk("rd_idle_rdata", 64'(bus.rdata), 64'd0);
    chk("rd_idle_ack", 64'(bus.ack), 64'd0);

    // Watchdog: memory never acks, forced completion in 8th BUSY cycle
    bus.mem_rdata = 32'hFFFF_FFFF;
    set_req(0, 1'b0, 32'h10, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        chk("wd_wait_ack", 64'(bus.ack), 64'd0);
        chk("wd_wait_terr", 64'(bus.timeout_err), 64'd0);
      end else begin
        chk("wd_fire_ack", 64'(bus.ack), 64'b001);
        chk("wd_fire_rdata", 64'(bus.rdata), 64'd0);
      end
    end
    tick();
    bus.req = '0;
    chk("wd_terr_set", 64'(bus.timeout_err), 64'd1);
    chk("wd_idle", 64'(state_dbg), 64'(IDLE));
    tick();
    chk("wd_terr_sticky", 64'(bus.timeout_err), 64'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("wd_terr_clr", 64'(bus.timeout_err), 64'd0);

    // Set and clear in the same cycle: set wins
    set_req(0, 1'b0, 32'h10, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 8) begin
        bus.err_clr = 1'b1;
        settle();
        chk("wd2_fire_ack", 64'(bus.ack), 64'b001);
      end
    end
    tick();
    bus.err_clr = 1'b0;
    bus.req     = '0;
    chk("wd2_set_wins", 64'(bus.timeout_err), 64'd1);

    // Stray mem_ack in IDLE
    tick();
    bus.mem_ack = 1'b1;
    settle();
    chk("stray_ack", 64'(bus.ack), 64'd0);
    tick();
    chk("stray_state", 64'(state_dbg), 64'(IDLE));
    chk("stray_ack2", 64'(bus.ack), 64'd0);
    bus.mem_ack = 1'b0;

    // Reset in the 3rd BUSY cycle; rr_ptr is 1 here, must return to 0
    set_req(1, 1'b0, 32'h44, 32'h0);
    tick();
    tick();
    tick();
    chk("rb_busy_pre", 64'(bus.busy), 64'd1);
    reset_n = 1'b0;
    settle();
    chk("rb_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rb_busy", 64'(bus.busy), 64'd0);
    chk("rb_ack", 64'(bus.ack), 64'd0);
    chk("rb_terr", 64'(bus.timeout_err), 64'd0);
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, AW'(32'h200 + i), '0);
    reset_n = 1'b1;
    tick();
    chk("rb_first_grant", 64'(bus.grant_id), 64'd0);
    chk("rb_first_addr", 64'(bus.mem_addr), 64'h200);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    bus.req     = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
